// File: rtl/gesture_sampler.sv
// Finger-contact conditioning: 2-flop sync, whole-hand debounce, and a
// valid/ready offer of each newly held shape with a wrapping display slot.

module gesture_sampler_lane (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic s,
    output logic p
);
    logic sync1;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            p     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            p     <= s;
        end
    end
endmodule

module gesture_sampler #(
    parameter int NFINGERS      = 5,
    parameter int STABLE_CYCLES = 250000,
    parameter int NSLOTS        = 5
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NFINGERS-1:0] finger_raw,
    input  logic                gesture_ready,
    input  logic                clear_overrun,
    output logic [NFINGERS-1:0] gesture,
    output logic                gesture_valid,
    output logic [2:0]          slot,
    output logic                overrun,
    output logic [NFINGERS-1:0] stable_level
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [2:0]       SLOT_MAX = 3'(NSLOTS);

    typedef enum logic {S_WAIT, S_VALID} state_t;

    logic [NFINGERS-1:0] s, p;
    logic [CNT_W-1:0]    cnt;
    logic                qualified;
    logic [NFINGERS-1:0] last_code, last_nxt, gesture_nxt;
    logic [2:0]          slot_nxt;
    logic                overrun_nxt, ovr_set;
    state_t              state, state_nxt;

    for (genvar i = 0; i < NFINGERS; i++) begin : g_lane
        gesture_sampler_lane u_lane (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .raw      (finger_raw[i]),
            .s        (s[i]),
            .p        (p[i])
        );
    end

    // Whole-hand count: any finger moving restarts qualification.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (s != p)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    assign qualified = (cnt == CNT_MAX) && (s == p);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            stable_level <= '0;
        else if (qualified)
            stable_level <= s;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= S_WAIT;
            gesture   <= '0;
            slot      <= '0;
            last_code <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gesture   <= gesture_nxt;
            slot      <= slot_nxt;
            last_code <= last_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gesture_nxt = gesture;
        slot_nxt    = slot;
        last_nxt    = last_code;
        ovr_set     = 1'b0;
        case (state)
            S_WAIT: begin
                if (qualified) begin
                    // All-open release re-arms repeating the same letter.
                    if (s == '0) begin
                        last_nxt = '0;
                    end else if (s != last_code) begin
                        gesture_nxt = s;
                        slot_nxt    = (slot == SLOT_MAX || slot == 3'd0) ? 3'd1 : slot + 3'd1;
                        state_nxt   = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (gesture_ready) begin
                    last_nxt  = gesture;
                    state_nxt = S_WAIT;
                end
                if (qualified && s != gesture && s != '0)
                    ovr_set = 1'b1;
            end
            default: state_nxt = S_WAIT;
        endcase
        overrun_nxt = ovr_set ? 1'b1 : (clear_overrun ? 1'b0 : overrun);
    end

    assign gesture_valid = (state == S_VALID);
endmodule

// File: tb/tb_gesture_sampler.sv
// Directed bench for gesture_sampler with STABLE_CYCLES = 8 (offer lands 12 edges after a change).

module tb_gesture_sampler;
    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [4:0] finger_raw;
    logic       gesture_ready;
    logic       clear_overrun;
    logic [4:0] gesture;
    logic       gesture_valid;
    logic [2:0] slot;
    logic       overrun;
    logic [4:0] stable_level;

    int n_chk = 0;
    int n_err = 0;
    int n_offer = 0;
    int base;
    logic [7:0] acc_q[$];

    gesture_sampler #(.NFINGERS(5), .STABLE_CYCLES(8), .NSLOTS(5)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .finger_raw    (finger_raw),
        .gesture_ready (gesture_ready),
        .clear_overrun (clear_overrun),
        .gesture       (gesture),
        .gesture_valid (gesture_valid),
        .slot          (slot),
        .overrun       (overrun),
        .stable_level  (stable_level)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge gesture_valid) n_offer++;

    always @(posedge CLOCK_50)
        if (!reset && gesture_valid && gesture_ready)
            acc_q.push_back({slot, gesture});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    logic [7:0] a;
    logic [2:0] exp_slot [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2};

    initial begin
        reset = 1'b1; finger_raw = '0; gesture_ready = 1'b0; clear_overrun = 1'b0;
        #3;
        check("rst_valid", gesture_valid, 0);
        check("rst_outs", {gesture, slot, overrun, stable_level}, 0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("rst_stable", stable_level, 0);

        // basic accept: offer lands exactly on edge 12
        gesture_ready = 1'b1;
        base = n_offer;
        finger_raw = 5'b00011;
        tick(11);
        check("basic_early", gesture_valid, 0);
        tick(1);
        check("basic_valid", gesture_valid, 1);
        check("basic_code", gesture, 5'b00011);
        check("basic_slot", slot, 1);
        check("basic_level", stable_level, 5'b00011);
        tick(1);
        check("basic_drop", gesture_valid, 0);
        tick(40);
        check("basic_hold_once", n_offer - base, 1);
        finger_raw = '0;
        tick(20);
        check("basic_level0", stable_level, 0);

        // debounce: 6-cycle pulse ignored, shortest qualifying pulse offered once
        base = n_offer;
        finger_raw = 5'b00100; tick(6);
        finger_raw = '0;       tick(20);
        check("deb_short", n_offer - base, 0);
        acc_q.delete();
        finger_raw = 5'b00100; tick(10);
        finger_raw = '0;       tick(20);
        check("deb_long", n_offer - base, 1);
        check("deb_acc_n", acc_q.size(), 1);
        if (acc_q.size() > 0) check("deb_acc", acc_q[0], {3'd2, 5'b00100});

        // reset while an offer is pending
        gesture_ready = 1'b0;
        finger_raw = 5'b01111;
        tick(12);
        check("mid_valid", gesture_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", gesture_valid, 0);
        check("mid_rst_outs", {gesture, slot, overrun, stable_level}, 0);
        finger_raw = '0;
        tick(2);
        reset = 1'b0;
        base = n_offer;
        tick(50);
        check("idle_no_offer", n_offer - base, 0);
        check("idle_valid", gesture_valid, 0);

        // repeat with release, slot wraps 5 -> 1
        gesture_ready = 1'b1;
        acc_q.delete();
        base = n_offer;
        for (int i = 0; i < 7; i++) begin
            finger_raw = 5'b00001; tick(20);
            finger_raw = '0;       tick(20);
        end
        check("rep_offers", n_offer - base, 7);
        check("rep_acc_n", acc_q.size(), 7);
        for (int i = 0; i < 7 && i < acc_q.size(); i++) begin
            a = acc_q[i];
            check($sformatf("rep_slot%0d", i), a, {exp_slot[i], 5'b00001});
        end

        // backpressure and overrun
        gesture_ready = 1'b0;
        finger_raw = 5'b10000;
        tick(12);
        check("bp_valid", gesture_valid, 1);
        check("bp_code", gesture, 5'b10000);
        check("bp_slot", slot, 3);
        check("bp_no_ovr", overrun, 0);
        finger_raw = 5'b01000;
        tick(20);
        check("bp_frozen", gesture, 5'b10000);
        check("bp_slot_frozen", slot, 3);
        check("bp_ovr", overrun, 1);
        clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
        check("bp_set_wins", overrun, 1);
        gesture_ready = 1'b1;
        tick(1);
        check("bp_accept_drop", gesture_valid, 0);
        tick(1);
        check("bp_next_valid", gesture_valid, 1);
        check("bp_next_code", gesture, 5'b01000);
        check("bp_next_slot", slot, 4);
        tick(1);
        finger_raw = '0;
        tick(20);
        check("bp_ovr_sticky", overrun, 1);
        clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
        check("bp_ovr_clear", overrun, 0);

        // same code re-qualified while pending: no overrun, single offer
        gesture_ready = 1'b0;
        base = n_offer;
        finger_raw = 5'b00110;
        tick(12);
        check("same_valid", gesture_valid, 1);
        check("same_slot", slot, 5);
        finger_raw = 5'b00111; tick(3);
        finger_raw = 5'b00110; tick(20);
        check("same_ovr", overrun, 0);
        check("same_code", gesture, 5'b00110);
        gesture_ready = 1'b1;
        tick(30);
        check("same_once", n_offer - base, 1);
        check("same_idle", gesture_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
